// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: shared raster timing types and the 1280x800@60 CVT preset
package vga_timing_gen_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_1280X800_H = '{active: 1280, fp: 72, sync: 128, bp: 200};
    localparam vga_timing_t VGA_1280X800_V = '{active: 800, fp: 3, sync: 6, bp: 22};

    localparam int SCREEN_W = 1280;
    localparam int SCREEN_H = 800;

    function automatic int axis_total(vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter: one raster axis -- wrapping count plus active/sync decode of the next count
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter vga_timing_t T = VGA_1280X800_H,
    parameter int          W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last,
    output logic         act_nxt,
    output logic         sync_nxt
);

    localparam int TOTAL = axis_total(T);

    logic [W-1:0] nxt;

    // Next count and window decode, so registered outputs line up with the count
    always_comb begin
        last     = count == W'(TOTAL - 1);
        nxt      = en ? (last ? '0 : count + 1'b1) : count;
        act_nxt  = nxt < W'(T.active);
        sync_nxt = nxt >= W'(T.active + T.fp) && nxt < W'(T.active + T.fp + T.sync);
    end

    // Count register parks at the last position so the first enable wraps to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= W'(TOTAL - 1);
        else        count <= nxt;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster coordinates, syncs, strobes and frame counter; VGA_SYNC_DELAY_EN delays hsync/vsync/active_area
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_1280X800_H.active,
    parameter int H_FP       = VGA_1280X800_H.fp,
    parameter int H_SYNC     = VGA_1280X800_H.sync,
    parameter int H_BP       = VGA_1280X800_H.bp,
    parameter int V_ACTIVE   = VGA_1280X800_V.active,
    parameter int V_FP       = VGA_1280X800_V.fp,
    parameter int V_SYNC     = VGA_1280X800_V.sync,
    parameter int V_BP       = VGA_1280X800_V.bp,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b1,
    parameter int SYNC_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [10:0] curr_x,
    output logic [9:0]  curr_y,
    output logic        active_area,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);

    localparam vga_timing_t H_T = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
    localparam vga_timing_t V_T = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
    localparam int H_TOTAL = axis_total(H_T);
    localparam int V_TOTAL = axis_total(V_T);

    if (H_TOTAL - 1 > 2047 || V_TOTAL - 1 > 1023 || SYNC_DELAY < 0) begin : g_size_err
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11/10-bit counters");
    end

    logic h_last, v_last, h_act, h_sync, v_act, v_sync, v_en;
    logic act_r, hs_r, vs_r, started;

    assign v_en = pix_en & h_last;

    vga_axis_counter #(.T(H_T), .W(11)) u_h (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (pix_en),
        .count    (curr_x),
        .last     (h_last),
        .act_nxt  (h_act),
        .sync_nxt (h_sync)
    );

    vga_axis_counter #(.T(V_T), .W(10)) u_v (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (v_en),
        .count    (curr_y),
        .last     (v_last),
        .act_nxt  (v_act),
        .sync_nxt (v_sync)
    );

    // Level outputs registered from next-state decode, aligned with curr_x/curr_y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r <= 1'b0;
            hs_r  <= ~H_POL;
            vs_r  <= ~V_POL;
        end else begin
            act_r <= h_act & v_act;
            hs_r  <= h_sync ? H_POL : ~H_POL;
            vs_r  <= v_sync ? V_POL : ~V_POL;
        end
    end

    // Single-clk strobes and frame counter; the wrap out of reset is not a completed frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
            started      <= 1'b0;
        end else begin
            line_start   <= v_en;
            frame_start  <= v_en & v_last;
            vblank_start <= v_en && curr_y == 10'(V_ACTIVE - 1);
            if (v_en && v_last) begin
                started     <= 1'b1;
                frame_count <= frame_count + 16'(started);
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic [SYNC_DELAY-1:0] act_d, hs_d, vs_d;

    // Delay line matching the renderer's registered colour path, stepped per pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_d <= '0;
            hs_d  <= {SYNC_DELAY{~H_POL}};
            vs_d  <= {SYNC_DELAY{~V_POL}};
        end else if (pix_en) begin
            act_d <= SYNC_DELAY'({act_d, act_r});
            hs_d  <= SYNC_DELAY'({hs_d, hs_r});
            vs_d  <= SYNC_DELAY'({vs_d, vs_r});
        end
    end

    assign active_area = act_d[SYNC_DELAY-1];
    assign hsync       = hs_d[SYNC_DELAY-1];
    assign vsync       = vs_d[SYNC_DELAY-1];
`else
    assign active_area = act_r;
    assign hsync       = hs_r;
    assign vsync       = vs_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table-driven checks of the raster generator at full and reduced timing
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;

    logic [10:0] b_x, s_x;
    logic [9:0]  b_y, s_y;
    logic        b_act, b_hs, b_vs, b_ls, b_fs, b_vb;
    logic        s_act, s_hs, s_vs, s_ls, s_fs, s_vb;
    logic [15:0] b_fc, s_fc;

    int total = 0;
    int pass = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_big (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_en       (pix_en),
        .curr_x       (b_x),
        .curr_y       (b_y),
        .active_area  (b_act),
        .hsync        (b_hs),
        .vsync        (b_vs),
        .line_start   (b_ls),
        .frame_start  (b_fs),
        .vblank_start (b_vb),
        .frame_count  (b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_en       (pix_en),
        .curr_x       (s_x),
        .curr_y       (s_y),
        .active_area  (s_act),
        .hsync        (s_hs),
        .vsync        (s_vs),
        .line_start   (s_ls),
        .frame_start  (s_fs),
        .vblank_start (s_vb),
        .frame_count  (s_fc)
    );

    logic [42:0] big_o, small_o;
    assign big_o   = {b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs, b_vb, b_fc};
    assign small_o = {s_x, s_y, s_act, s_hs, s_vs, s_ls, s_fs, s_vb, s_fc};

    typedef struct {
        int          p;
        bit          sm;
        logic [42:0] exp;
    } vec_t;

    vec_t tab[$];

    function automatic logic [42:0] pk(int x, int y, bit a, bit h, bit v, bit ls, bit fs, bit vb, int fc);
        return {11'(x), 10'(y), a, h, v, ls, fs, vb, 16'(fc)};
    endfunction

    task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got {x,y,act,hs,vs,ls,fs,vb,fc}=%h expected %h", name, act, exp);
        else
            pass++;
    endtask

    task automatic tick(input bit en);
        pix_en = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p;
        tab.push_back('{1,    1'b1, pk(0,    0,  1, 1, 0, 1, 1, 0, 0)});
        tab.push_back('{1,    1'b0, pk(0,    0,  1, 1, 0, 1, 1, 0, 0)});
        tab.push_back('{2,    1'b0, pk(1,    0,  1, 1, 0, 0, 0, 0, 0)});
        tab.push_back('{11,   1'b1, pk(10,   0,  0, 0, 0, 0, 0, 0, 0)});
        tab.push_back('{14,   1'b1, pk(13,   0,  0, 1, 0, 0, 0, 0, 0)});
        tab.push_back('{91,   1'b1, pk(0,    6,  0, 1, 0, 1, 0, 1, 0)});
        tab.push_back('{92,   1'b1, pk(1,    6,  0, 1, 0, 0, 0, 0, 0)});
        tab.push_back('{105,  1'b1, pk(14,   6,  0, 1, 0, 0, 0, 0, 0)});
        tab.push_back('{106,  1'b1, pk(0,    7,  0, 1, 1, 1, 0, 0, 0)});
        tab.push_back('{135,  1'b1, pk(14,   8,  0, 1, 1, 0, 0, 0, 0)});
        tab.push_back('{136,  1'b1, pk(0,    9,  0, 1, 0, 1, 0, 0, 0)});
        tab.push_back('{166,  1'b1, pk(0,    0,  1, 1, 0, 1, 1, 0, 1)});
        tab.push_back('{167,  1'b1, pk(1,    0,  1, 1, 0, 0, 0, 0, 1)});
        tab.push_back('{331,  1'b1, pk(0,    0,  1, 1, 0, 1, 1, 0, 2)});
        tab.push_back('{1280, 1'b0, pk(1279, 0,  1, 1, 0, 0, 0, 0, 0)});
        tab.push_back('{1281, 1'b0, pk(1280, 0,  0, 1, 0, 0, 0, 0, 0)});
        tab.push_back('{1352, 1'b0, pk(1351, 0,  0, 1, 0, 0, 0, 0, 0)});
        tab.push_back('{1353, 1'b0, pk(1352, 0,  0, 0, 0, 0, 0, 0, 0)});
        tab.push_back('{1480, 1'b0, pk(1479, 0,  0, 0, 0, 0, 0, 0, 0)});
        tab.push_back('{1481, 1'b0, pk(1480, 0,  0, 1, 0, 0, 0, 0, 0)});
        tab.push_back('{1680, 1'b0, pk(1679, 0,  0, 1, 0, 0, 0, 0, 0)});
        tab.push_back('{1681, 1'b0, pk(0,    1,  1, 1, 0, 1, 0, 0, 0)});

        repeat (3) @(posedge clk);
        #1;
        check("reset_big",   big_o,   pk(1679, 830, 0, 1, 0, 0, 0, 0, 0));
        check("reset_small", small_o, pk(14,   10,  0, 1, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        p = 0;
        foreach (tab[i]) begin
            while (p < tab[i].p) begin
                tick(1'b1);
                p++;
            end
            check($sformatf("tab%0d_p%0d_%s", i, tab[i].p, tab[i].sm ? "small" : "big"),
                  tab[i].sm ? small_o : big_o, tab[i].exp);
        end

        repeat (5) tick(1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_big",   big_o,   pk(1679, 830, 0, 1, 0, 0, 0, 0, 0));
        check("async_reset_small", small_o, pk(14,   10,  0, 1, 0, 0, 0, 0, 0));
        repeat (3) tick(1'b1);
        check("held_reset_small", small_o, pk(14, 10, 0, 1, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        tick(1'b1);
        check("restart_big",   big_o,   pk(0, 0, 1, 1, 0, 1, 1, 0, 0));
        check("restart_small", small_o, pk(0, 0, 1, 1, 0, 1, 1, 0, 0));

        tick(1'b0);
        check("strobe_drop_big",   big_o,   pk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        check("strobe_drop_small", small_o, pk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 1; i < 15; i++) begin
            bit a, h;
            a = i < 8;
            h = !(i >= 10 && i <= 12);
            tick(1'b1);
            check($sformatf("toggle_on_x%0d", i),  small_o, pk(i, 0, a, h, 0, 0, 0, 0, 0));
            tick(1'b0);
            check($sformatf("toggle_off_x%0d", i), small_o, pk(i, 0, a, h, 0, 0, 0, 0, 0));
        end
        tick(1'b1);
        check("toggle_wrap_on",  small_o, pk(0, 1, 1, 1, 0, 1, 0, 0, 0));
        tick(1'b0);
        check("toggle_wrap_off", small_o, pk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        check("toggle_big",      big_o,   pk(15, 0, 1, 1, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster scan coordinates and sync signals that the Tetris renderer consumes: curr_x, curr_y, active_area, plus hsync/vsync to the VGA connector.
- Default timing is 1280x800@60 CVT: 83.5 MHz pixel rate, 1680x831 total.
- Also emits frame, line and vblank strobes and a frame counter. Game logic uses these to latch the display field and advance per-frame timers.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 72, horizontal front porch
- H_SYNC, 128, hsync width
- H_BP, 200, horizontal back porch
- V_ACTIVE, 800, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 22, vertical back porch
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 1, vsync active level
- SYNC_DELAY, 2, pipeline stages applied to hsync/vsync/active_area when VGA_SYNC_DELAY_EN is defined

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- pix_en  in  1  pixel-rate clock enable; all counters and strobes advance only on cycles with pix_en=1
- curr_x  out  11  horizontal count, 0..H_TOTAL-1
- curr_y  out  10  vertical count, 0..V_TOTAL-1
- active_area  out  1  high when curr_x<H_ACTIVE and curr_y<V_ACTIVE
- hsync  out  1  horizontal sync at H_POL level when active
- vsync  out  1  vertical sync at V_POL level when active
- line_start  out  1  one-clk pulse when curr_x becomes 0
- frame_start  out  1  one-clk pulse when (curr_x,curr_y) becomes (0,0)
- vblank_start  out  1  one-clk pulse when curr_y becomes V_ACTIVE at curr_x=0
- frame_count  out  16  number of completed frames, wraps modulo 2^16

Behaviour:
- Derived values: H_TOTAL = sum of the H parameters; V_TOTAL = sum of the V parameters.
- Elaboration check: H_TOTAL-1 must fit 11 bits and V_TOTAL-1 must fit 10 bits; otherwise $error.
- Reset values (async, while rst_n=0):
  - curr_x=H_TOTAL-1, curr_y=V_TOTAL-1, active_area=0
  - hsync=~H_POL, vsync=~V_POL
  - all strobes 0, frame_count=0
- After reset, the first pix_en cycle wraps the counters to (0,0), asserts frame_start and line_start, and leaves frame_count at 0. The reset wrap is not counted.
- On each pix_en cycle:
  - curr_x increments; at H_TOTAL-1 it wraps to 0 and curr_y increments.
  - curr_y wraps V_TOTAL-1 -> 0.
  - frame_count increments on every wrap to (0,0) except the first after reset.
- All outputs are registered and decoded from next-state counts, so they are cycle-aligned with curr_x/curr_y: zero relative latency.
- hsync is asserted for H_ACTIVE+H_FP <= curr_x < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted for V_ACTIVE+V_FP <= curr_y < V_ACTIVE+V_FP+V_SYNC. It changes only together with curr_x=0.
- Strobes are high for exactly one clk. They deassert on the next clk even if pix_en=0.
- With pix_en=0, counters, levels and frame_count hold.
- With pix_en tied to 1, every clk is one pixel.
- Reset mid-frame: outputs return immediately to reset values; no partial strobes; counters restart as after power-up.
- frame_count at 16'hFFFF wraps to 0 with no flag.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- Defined: hsync, vsync and active_area pass through a SYNC_DELAY-stage shift register advanced on pix_en. This matches the renderer's registered colour path. The delay stages reset to the inactive values.
  - curr_x, curr_y and the strobes are not delayed.
- Undefined: no delay stages; SYNC_DELAY is ignored.

Decomposition:
- Shared package holds:
  - the vga_timing_t struct (active, fp, sync, bp per axis)
  - localparams for the 1280x800@60 preset
  - SCREEN_W=1280 and SCREEN_H=800, also used by renderer grid centring
- One natural sub-module: vga_axis_counter (count, wrap, sync-window and active decode for one axis, with a carry-in enable). It is instantiated for H, and for V with carry = H wrap.

Test Plan:
- Release reset, pix_en=1: cycle 1 gives (0,0) with frame_start=1 and line_start=1; frame_count=0.
- Scan one line: active_area falls at curr_x=1280; hsync=0 for curr_x 1352..1479, 1 elsewhere; curr_x wraps 1679->0 and curr_y goes to 1.
- Full frame: vblank_start at (0,800); vsync=1 for curr_y 803..808; after 1680*831 pix_en cycles, frame_start recurs and frame_count=1.
- pix_en toggling 1,0 alternately: counts advance every 2 clks; every strobe stays exactly 1 clk wide.
- Assert rst_n=0 at (700,400) for 3 clks: immediate return to the reset values listed in Behaviour; the next pix_en cycle gives (0,0) with frame_start=1 and frame_count=0.
- With VGA_SYNC_DELAY_EN, SYNC_DELAY=2: hsync assertion observed 2 pix_en cycles after curr_x=1352; curr_x timing unchanged.
